// File: rtl/btb_controller.sv
// Branch target buffer controller: combinational fetch-side prediction,
// EX-side resolved-branch updates with allocation/replacement, a
// post-reset / on-request table clear sweep, and a mispredict counter.
module btb_controller #(
  parameter int ENTRIES    = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  predict_valid,
  output logic [ADDR_WIDTH-1:0] predict_target,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_taken,
  output logic                  update_ready,
  input  logic                  clear_req,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [IDX_W-1:0]      idx_r;
  logic [IDX_W-1:0]      vptr_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  logic [ENTRIES-1:0]    valid_r;
  logic [ADDR_WIDTH-1:0] tag_r    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_r [ENTRIES];
  logic [1:0]            ctr_r    [ENTRIES];

  logic [ENTRIES-1:0]    lk_match_s;
  logic [ENTRIES-1:0]    up_match_s;
  logic                  lk_hit_s;
  logic                  up_hit_s;
  logic [IDX_W-1:0]      lk_idx_s;
  logic [IDX_W-1:0]      up_idx_s;
  logic [IDX_W-1:0]      alloc_idx_s;
  logic                  table_full_s;
  logic                  pred_taken_s;
  logic                  update_fire_s;

  // Lowest set bit position of a vector; lowest index wins on multiple hits.
  function automatic logic [IDX_W-1:0] first_set(input logic [ENTRIES-1:0] vec);
    logic [IDX_W-1:0] pos;
    pos = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        pos = IDX_W'(i);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

  // Tag compare of every entry against both the fetch PC and the EX PC.
  always_comb begin
    lk_match_s = '0;
    up_match_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match_s[i] = valid_r[i] & (tag_r[i] == lookup_pc);
      up_match_s[i] = valid_r[i] & (tag_r[i] == update_pc);
    end
  end

  assign lk_hit_s      = |lk_match_s;
  assign up_hit_s      = |up_match_s;
  assign lk_idx_s      = first_set(lk_match_s);
  assign up_idx_s      = first_set(up_match_s);
  assign table_full_s  = &valid_r;
  // Prefer an empty slot; only evict (round-robin) when the table is full.
  assign alloc_idx_s   = table_full_s ? vptr_r : first_set(~valid_r);
  assign pred_taken_s  = up_hit_s & ctr_r[up_idx_s][1];
  assign update_fire_s = update_valid & (state_r == IDLE);

  assign busy             = (state_r == CLEAR);
  assign update_ready     = (state_r == IDLE);
  assign mispredict_count = cnt_r;

  // Fetch-side prediction; suppressed entirely while the table is being wiped.
  always_comb begin
    predict_valid  = 1'b0;
    predict_target = '0;
    if (lk_hit_s && (state_r == IDLE)) begin
      predict_valid  = ctr_r[lk_idx_s][1];
      predict_target = target_r[lk_idx_s];
    end else begin
      predict_valid  = 1'b0;
      predict_target = '0;
    end
  end

  // Next-state: a clear request always (re)starts the sweep.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear_req) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        if (clear_req) begin
          state_nxt_s = CLEAR;
        end else if (idx_r == IDX_W'(ENTRIES - 1)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: state_nxt_s = CLEAR;
    endcase
  end

  // State, sweep index, victim pointer, counter and table contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= CLEAR;
      idx_r   <= '0;
      vptr_r  <= '0;
      cnt_r   <= '0;
      valid_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        CLEAR: begin
          valid_r[idx_r]  <= 1'b0;
          ctr_r[idx_r]    <= 2'b01;
          tag_r[idx_r]    <= '0;
          target_r[idx_r] <= '0;
          if (clear_req) begin
            idx_r  <= '0;
            vptr_r <= '0;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        IDLE: begin
          if (update_fire_s) begin
            if (pred_taken_s != update_taken) begin
              cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
            if (up_hit_s) begin
              if (update_taken) begin
                if (ctr_r[up_idx_s] != 2'b11) begin
                  ctr_r[up_idx_s] <= ctr_r[up_idx_s] + 2'b01;
                end
                target_r[up_idx_s] <= update_target;
              end else if (ctr_r[up_idx_s] != 2'b00) begin
                ctr_r[up_idx_s] <= ctr_r[up_idx_s] - 2'b01;
              end
            end else if (update_taken) begin
              valid_r[alloc_idx_s]  <= 1'b1;
              tag_r[alloc_idx_s]    <= update_pc;
              target_r[alloc_idx_s] <= update_target;
              ctr_r[alloc_idx_s]    <= 2'b10;
              if (table_full_s) begin
                vptr_r <= vptr_r + IDX_W'(1);
              end
            end
          end
          // A same-cycle clear wins over the victim pointer bump above.
          if (clear_req) begin
            idx_r  <= '0;
            vptr_r <= '0;
          end
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_controller.sv
// Scoreboard-driven bench for btb_controller: expectations are queued when
// stimulus is driven and compared against DUT outputs on the falling edge.
module tb_btb_controller;

  localparam int ENTRIES = 8;
  localparam int AW      = 16;
  localparam int CW      = 16;

  localparam int S_PV   = 0;
  localparam int S_PT   = 1;
  localparam int S_BUSY = 2;
  localparam int S_RDY  = 3;
  localparam int S_CNT  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] lookup_pc;
  logic          predict_valid;
  logic [AW-1:0] predict_target;
  logic          update_valid;
  logic [AW-1:0] update_pc;
  logic [AW-1:0] update_target;
  logic          update_taken;
  logic          update_ready;
  logic          clear_req;
  logic          busy;
  logic [CW-1:0] mispredict_count;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  btb_controller #(.ENTRIES(ENTRIES), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .lookup_pc        (lookup_pc),
    .predict_valid    (predict_valid),
    .predict_target   (predict_target),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_target    (update_target),
    .update_taken     (update_taken),
    .update_ready     (update_ready),
    .clear_req        (clear_req),
    .busy             (busy),
    .mispredict_count (mispredict_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_PV:    return {31'd0, predict_valid};
      S_PT:    return {16'd0, predict_target};
      S_BUSY:  return {31'd0, busy};
      S_RDY:   return {31'd0, update_ready};
      S_CNT:   return {16'd0, mispredict_count};
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_drain();
    sb_item_t it;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check_val(it.tag, observe(it.sel), it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [AW-1:0] pc, input logic pv, input logic [AW-1:0] pt);
    lookup_pc = pc;
    sb_push({tag, ".pv"}, S_PV, {31'd0, pv});
    sb_push({tag, ".pt"}, S_PT, {16'd0, pt});
    sb_drain();
    tick();
  endtask

  task automatic upd(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic tk);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_target = tgt;
    update_taken  = tk;
    tick();
    update_valid  = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    sb_push(tag, S_CNT, 32'(exp));
    sb_drain();
    tick();
  endtask

  task automatic chk_idle(input string tag);
    sb_push({tag, ".busy"}, S_BUSY, 32'd0);
    sb_push({tag, ".rdy"}, S_RDY, 32'd1);
    sb_drain();
    tick();
  endtask

  // n busy cycles; optionally present a taken update every cycle (must be dropped)
  task automatic busy_window(input string tag, input int n, input bit with_upd);
    for (int i = 0; i < n; i++) begin
      lookup_pc     = AW'($urandom);
      update_valid  = with_upd;
      update_pc     = 16'h0600;
      update_target = 16'h6000;
      update_taken  = 1'b1;
      sb_push($sformatf("%s.busy%0d", tag, i), S_BUSY, 32'd1);
      sb_push($sformatf("%s.rdy%0d", tag, i), S_RDY, 32'd0);
      sb_push($sformatf("%s.pv%0d", tag, i), S_PV, 32'd0);
      sb_push($sformatf("%s.pt%0d", tag, i), S_PT, 32'd0);
      sb_drain();
      tick();
      update_valid = 1'b0;
    end
  endtask

  initial begin
    reset         = 1'b0;
    lookup_pc     = 16'h0010;
    update_valid  = 1'b0;
    update_pc     = 16'h0000;
    update_target = 16'h0000;
    update_taken  = 1'b0;
    clear_req     = 1'b0;

    // Reset held low
    repeat (3) tick();
    sb_push("rst.busy", S_BUSY, 32'd1);
    sb_push("rst.rdy", S_RDY, 32'd0);
    sb_push("rst.pv", S_PV, 32'd0);
    sb_push("rst.pt", S_PT, 32'd0);
    sb_push("rst.cnt", S_CNT, 32'd0);
    sb_drain();
    tick();
    reset = 1'b1;
    busy_window("rstclr", ENTRIES, 1'b0);
    chk_idle("rstdone");

    // Allocate; same-cycle lookup sees the old (empty) table
    lookup_pc     = 16'h0010;
    update_valid  = 1'b1;
    update_pc     = 16'h0010;
    update_target = 16'h0040;
    update_taken  = 1'b1;
    sb_push("nobypass.pv", S_PV, 32'd0);
    sb_push("nobypass.pt", S_PT, 32'd0);
    sb_drain();
    tick();
    update_valid = 1'b0;
    look("alloc", 16'h0010, 1'b1, 16'h0040);
    chk_cnt("alloc.cnt", 1);

    // Saturation then decay
    upd(16'h0010, 16'h0040, 1'b1);
    upd(16'h0010, 16'h0040, 1'b1);
    upd(16'h0010, 16'h0044, 1'b1);
    look("sat3", 16'h0010, 1'b1, 16'h0044);
    chk_cnt("sat3.cnt", 1);
    upd(16'h0010, 16'h0099, 1'b0);
    upd(16'h0010, 16'h0099, 1'b0);
    look("ctr1", 16'h0010, 1'b0, 16'h0044);
    chk_cnt("ctr1.cnt", 3);
    upd(16'h0010, 16'h0099, 1'b0);
    look("ctr0", 16'h0010, 1'b0, 16'h0044);
    chk_cnt("ctr0.cnt", 3);

    // Clear, then miss/not-taken on an empty table
    clear_req = 1'b1;
    chk_idle("clr1.req");
    clear_req = 1'b0;
    busy_window("clr1", ENTRIES, 1'b0);
    chk_idle("clr1.done");
    upd(16'h0300, 16'h3000, 1'b0);
    look("mnt", 16'h0300, 1'b0, 16'h0000);
    look("wiped", 16'h0010, 1'b0, 16'h0000);
    chk_cnt("mnt.cnt", 3);

    // Fill and replace
    for (int i = 0; i < ENTRIES; i++) begin
      upd(16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b1);
    end
    look("fill7", 16'h0107, 1'b1, 16'h1007);
    chk_cnt("fill.cnt", 11);
    upd(16'h0200, 16'h2000, 1'b1);
    look("rep0.old", 16'h0100, 1'b0, 16'h0000);
    look("rep0.new", 16'h0200, 1'b1, 16'h2000);
    look("rep0.keep", 16'h0101, 1'b1, 16'h1001);
    upd(16'h0201, 16'h2001, 1'b1);
    look("rep1.old", 16'h0101, 1'b0, 16'h0000);
    look("rep1.new", 16'h0201, 1'b1, 16'h2001);
    look("rep1.keep", 16'h0102, 1'b1, 16'h1002);
    chk_cnt("rep.cnt", 13);

    // Update and clear in the same idle cycle; updates during sweep dropped
    update_valid  = 1'b1;
    update_pc     = 16'h0500;
    update_target = 16'h5000;
    update_taken  = 1'b1;
    clear_req     = 1'b1;
    chk_idle("clr2.req");
    update_valid  = 1'b0;
    clear_req     = 1'b0;
    busy_window("clr2", ENTRIES, 1'b1);
    chk_idle("clr2.done");
    chk_cnt("clr2.cnt", 14);
    look("clr2.a", 16'h0500, 1'b0, 16'h0000);
    look("clr2.b", 16'h0600, 1'b0, 16'h0000);
    look("clr2.c", 16'h0201, 1'b0, 16'h0000);

    // Restart sweep at the 4th busy cycle
    clear_req = 1'b1;
    chk_idle("clr3.req");
    clear_req = 1'b0;
    busy_window("clr3a", 3, 1'b0);
    clear_req = 1'b1;
    busy_window("clr3r", 1, 1'b0);
    clear_req = 1'b0;
    busy_window("clr3b", ENTRIES, 1'b0);
    chk_idle("clr3.done");
    upd(16'h0700, 16'h7000, 1'b1);
    look("post", 16'h0700, 1'b1, 16'h7000);
    chk_cnt("post.cnt", 15);

    // Reset mid-sweep overrides and restarts from entry 0
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    sb_push("rst2.busy", S_BUSY, 32'd1);
    sb_push("rst2.cnt", S_CNT, 32'd0);
    sb_drain();
    tick();
    reset = 1'b1;
    busy_window("rst2clr", ENTRIES, 1'b0);
    chk_idle("rst2.done");
    look("rst2.miss", 16'h0700, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_controller.md
# btb_controller

Branch target buffer controller that owns prediction state for the fetch stage and the branch resolution logic in EX. Each entry holds a tag, a target and a 2-bit saturating direction counter. Fetch reads a predicted target combinationally every cycle. EX writes resolved outcomes back. The block sequences a table-clear sweep after reset and on request, and it picks victims for allocation.

## Interface
- ENTRIES, 8, number of table entries (power of two, ≥2)
- ADDR_WIDTH, 16, PC/target width
- CNT_WIDTH, 16, mispredict counter width
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- lookup_pc  in  ADDR_WIDTH  fetch PC to predict
- predict_valid  out  1  predict taken (hit and counter MSB = 1)
- predict_target  out  ADDR_WIDTH  target of hit entry, 0 on miss
- update_valid  in  1  resolved branch present in EX
- update_pc  in  ADDR_WIDTH  PC of resolved branch
- update_target  in  ADDR_WIDTH  resolved taken-target
- update_taken  in  1  actual branch direction
- update_ready  out  1  update accepted this cycle when high
- clear_req  in  1  invalidate whole table (pulse)
- busy  out  1  clear sweep in progress
- mispredict_count  out  CNT_WIDTH  count of updates whose predicted direction differed from the actual one

## Operation
- Each entry has the following fields: valid, tag[ADDR_WIDTH], target[ADDR_WIDTH], ctr[1:0], plus a victim pointer vptr[log2(ENTRIES)].
- **Lookup** (combinational):
  - An entry hits when valid=1 and tag==lookup_pc.
  - If several entries match, the lowest index wins.
  - predict_valid = hit & ctr[1] & ~busy.
  - predict_target = target on hit, else 0. It is also 0 while busy.
- **Update** (applied on the edge where update_valid & update_ready):
  - *Hit, taken:* ctr = min(ctr+1, 3); target = update_target.
  - *Hit, not taken:* ctr = max(ctr-1, 0); target unchanged.
  - *Miss, taken:* allocate an entry.
    - Use the lowest-index invalid entry if one exists.
    - Otherwise use entry vptr, then vptr = vptr+1 mod ENTRIES.
    - The new entry gets valid=1, tag=update_pc, target=update_target, ctr=2'b10.
  - *Miss, not taken:* the table is unchanged.
  - The hit/miss decision for an update uses the update_pc match, evaluated the same way as lookup.
- **Mispredict counting:**
  - Predicted direction = hit & ctr[1], evaluated on update_pc before the update is applied.
  - mispredict_count increments by 1 when the predicted direction ≠ update_taken.
  - The counter wraps at 2^CNT_WIDTH.
  - The clear sweep does not reset it.
- **FSM:** two states, IDLE and CLEAR.
  - *CLEAR:*
    - Each cycle clears entry idx: valid=0, ctr=2'b01, tag=0, target=0.
    - idx increments each cycle.
    - After idx = ENTRIES-1 is cleared, the FSM moves to IDLE.
    - busy=1 and update_ready=0 throughout. Updates presented during CLEAR are dropped, not queued.
  - *IDLE:* busy=0, update_ready=1.
  - *clear_req in IDLE:* next state is CLEAR with idx=0 and vptr=0.
  - *clear_req during CLEAR:* restarts the sweep at idx=0.

## Timing
- **While reset=0 (sampled on the edge):**
  - State is CLEAR, idx=0, vptr=0, mispredict_count=0.
  - Outputs: busy=1, update_ready=0, predict_valid=0, predict_target=0.
- **After reset release:**
  - The first edge with reset=1 clears entry 0.
  - busy stays high for exactly ENTRIES cycles after release, then falls.
- **clear_req asserted in cycle N:** busy=1 from cycle N+1 through N+ENTRIES, and 0 in cycle N+ENTRIES+1.
- **Update accepted in cycle N:** the table change is visible to lookup from cycle N+1. A same-cycle lookup of the same PC sees the old contents (no bypass).
- **Reset asserted mid-sweep or mid-operation:** it overrides everything; the sweep restarts from 0 after release.
- **Update and clear_req in the same IDLE cycle:** the update is applied first; the clear begins the next cycle and wipes it.

## Test plan
- **Reset clear:** hold reset=0 for 3 cycles, release → busy=1 for 8 cycles then 0; predict_valid=0 for any lookup_pc.
- **Allocate and predict:** update pc=0x0010, target=0x0040, taken=1 → next cycle lookup 0x0010 gives predict_valid=1, predict_target=0x0040; mispredict_count=1.
- **Counter saturation:** three more taken updates on 0x0010 (ctr=3), then two not-taken updates → ctr=1, predict_valid=0; one more not-taken → ctr=0, still a hit with predict_valid=0.
- **Replacement:** with ENTRIES=8, allocate pcs 0x0100..0x0107 (all taken), then allocate 0x0200 → entry 0 (0x0100) is replaced and vptr=1; allocate 0x0201 → entry 1 is replaced.
- **Clear mid-operation:**
  - Fill entries, pulse clear_req → busy high for 8 cycles; updates presented during the sweep leave the table unchanged.
  - Pulse clear_req again at the 4th busy cycle → the sweep restarts; busy lasts 8 cycles from the second pulse.
- **Miss, not taken:** update pc=0x0300, taken=0 on an empty table → no allocation; lookup 0x0300 misses; mispredict_count unchanged.
